// File: rtl/sd_spi_card_model.sv
// SD card SPI-mode responder: synchronizes host SPI pins into clk, decodes 48-bit
// commands and shifts out R1/R7/R3 responses. Define SD_CARD_CRC_CHECK_EN to enforce CRC7.
module sd_spi_card_model #(
    parameter int unsigned INIT_POLLS = 2,
    parameter int unsigned NCR_BYTES  = 1,
    parameter logic [31:0] OCR        = 32'hC0FF8000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sd_cclk,
    input  logic       sd_cs,
    input  logic       sd_mosi_cmd,
    output logic       sd_miso_data,
    output logic       card_idle,
    output logic       cmd_valid,
    output logic [5:0] cmd_index
);
    typedef enum logic [2:0] {HUNT, RX_CMD, DECODE, NCR, TX_RESP} state_t;

    localparam logic [15:0] POLL_MAX = 16'(INIT_POLLS);
    localparam logic [15:0] NCR_LOAD = 16'(NCR_BYTES * 8);

    state_t      state, state_next;
    logic [1:0]  cclk_sync, cs_sync, mosi_sync;
    logic        cclk_d;
    logic        cclk_s, cs_s, mosi_s;
    logic        shift_en, tx_en, frame_done;
    logic [47:0] rx_sr, rx_next;
    logic [5:0]  bit_cnt;
    logic        hunt_zero;
    logic [39:0] resp_sr;
    logic [5:0]  tx_cnt;
    logic [15:0] ncr_cnt;
    logic        app_cmd;
    logic [15:0] poll_cnt;

    logic [5:0]  dec_idx;
    logic [11:0] dec_arg;
    logic [7:0]  r1;
    logic [39:0] dec_resp;
    logic [5:0]  dec_len;
    logic        dec_idle, dec_app;
    logic [15:0] dec_polls, poll_inc;
    logic        crc_bad;
    logic        unused_bits;

    assign cclk_s   = cclk_sync[1];
    assign cs_s     = cs_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign shift_en = cclk_s & ~cclk_d & ~cs_s;
    assign tx_en    = ~cclk_s & cclk_d & ~cs_s;
    assign rx_next  = {rx_sr[46:0], mosi_s};
    assign dec_idx  = rx_sr[45:40];
    assign dec_arg  = rx_sr[19:8];
    assign unused_bits = ^{rx_sr[47:46], rx_sr[39:20], rx_sr[7:0]};

`ifdef SD_CARD_CRC_CHECK_EN
    function automatic logic [6:0] crc7(input logic [39:0] bits);
        logic [6:0]  c;
        logic [39:0] b;
        logic        fb;
        c = '0;
        b = bits;
        for (int unsigned i = 0; i < 40; i++) begin
            fb = c[6] ^ b[39];
            b  = {b[38:0], 1'b0};
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction
    assign crc_bad = (crc7(rx_sr[47:8]) != rx_sr[7:1]);
`else
    assign crc_bad = 1'b0;
`endif

    // Response image is left-aligned so TX_RESP always shifts from bit 39.
    always_comb begin
        r1        = {7'b0, card_idle};
        dec_resp  = '0;
        dec_len   = 6'd8;
        dec_idle  = card_idle;
        dec_app   = 1'b0;
        dec_polls = poll_cnt;
        poll_inc  = (poll_cnt >= POLL_MAX) ? poll_cnt : poll_cnt + 16'd1;
        if (crc_bad) begin
            dec_resp = {r1 | 8'h08, 32'h0};
            dec_app  = app_cmd;
        end else begin
            case (dec_idx)
                6'd0: begin
                    dec_resp  = {8'h01, 32'h0};
                    dec_idle  = 1'b1;
                    dec_polls = '0;
                end
                6'd8: begin
                    dec_resp = {r1, 20'h0, dec_arg};
                    dec_len  = 6'd40;
                end
                6'd55: begin
                    dec_resp = {r1, 32'h0};
                    dec_app  = 1'b1;
                end
                6'd41: begin
                    if (app_cmd) begin
                        dec_polls = poll_inc;
                        if (poll_inc < POLL_MAX) begin
                            dec_resp = {8'h01, 32'h0};
                        end else begin
                            dec_resp = '0;
                            dec_idle = 1'b0;
                        end
                    end else begin
                        dec_resp = {r1 | 8'h04, 32'h0};
                    end
                end
                6'd58: begin
                    dec_resp = {r1, OCR};
                    dec_len  = 6'd40;
                end
                default: dec_resp = {r1 | 8'h04, 32'h0};
            endcase
        end
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            HUNT:    if (shift_en && hunt_zero && mosi_s) state_next = RX_CMD;
            RX_CMD:  if (shift_en && bit_cnt == 6'd47) begin
                         state_next = DECODE;
                         frame_done = 1'b1;
                     end
            DECODE:  state_next = (NCR_BYTES == 0) ? TX_RESP : NCR;
            NCR:     if (tx_en && ncr_cnt == 16'd1) state_next = TX_RESP;
            TX_RESP: if (tx_en && tx_cnt == 6'd0) state_next = HUNT;
            default: state_next = HUNT;
        endcase
        if (cs_s) begin
            state_next = HUNT;
            frame_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cclk_sync    <= '0;
            cs_sync      <= '1;
            mosi_sync    <= '1;
            cclk_d       <= 1'b0;
            sd_miso_data <= 1'b1;
            card_idle    <= 1'b1;
            cmd_valid    <= 1'b0;
            cmd_index    <= '0;
            app_cmd      <= 1'b0;
            poll_cnt     <= '0;
            rx_sr        <= '0;
            bit_cnt      <= '0;
            hunt_zero    <= 1'b0;
            resp_sr      <= '0;
            tx_cnt       <= '0;
            ncr_cnt      <= '0;
        end else begin
            cclk_sync <= {cclk_sync[0], sd_cclk};
            cs_sync   <= {cs_sync[0], sd_cs};
            mosi_sync <= {mosi_sync[0], sd_mosi_cmd};
            cclk_d    <= cclk_s;
            cmd_valid <= frame_done;
            if (frame_done) cmd_index <= rx_next[45:40];
            if (cs_s) begin
                sd_miso_data <= 1'b1;
                hunt_zero    <= 1'b0;
            end else begin
                case (state)
                    HUNT: if (shift_en) begin
                        rx_sr     <= rx_next;
                        hunt_zero <= ~mosi_s;
                        bit_cnt   <= 6'd2;
                    end
                    RX_CMD: begin
                        hunt_zero <= 1'b0;
                        if (shift_en) begin
                            rx_sr   <= rx_next;
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    DECODE: begin
                        resp_sr   <= dec_resp;
                        tx_cnt    <= dec_len;
                        ncr_cnt   <= NCR_LOAD;
                        card_idle <= dec_idle;
                        app_cmd   <= dec_app;
                        poll_cnt  <= dec_polls;
                    end
                    NCR: if (tx_en) begin
                        sd_miso_data <= 1'b1;
                        ncr_cnt      <= ncr_cnt - 16'd1;
                    end
                    TX_RESP: if (tx_en) begin
                        // One extra fall after the last bit returns the line to idle.
                        if (tx_cnt != 6'd0) begin
                            sd_miso_data <= resp_sr[39];
                            resp_sr      <= {resp_sr[38:0], 1'b0};
                            tx_cnt       <= tx_cnt - 6'd1;
                        end else begin
                            sd_miso_data <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_spi_card_model.sv
// Self-checking bench for sd_spi_card_model: directed SD init flow plus randomized
// commands/aborts checked against a command-level card model.
module tb_sd_spi_card_model;
    localparam int          INIT_POLLS = 2;
    localparam int          NCR_BYTES  = 1;
    localparam logic [31:0] OCR        = 32'hC0FF8000;
    localparam int          HALF       = 40;
`ifdef SD_CARD_CRC_CHECK_EN
    localparam logic [39:0] CRC_EXP = 40'h09;
`else
    localparam logic [39:0] CRC_EXP = 40'h01;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sd_cclk = 1'b0;
    logic       sd_cs = 1'b1;
    logic       sd_mosi_cmd = 1'b1;
    logic       sd_miso_data;
    logic       card_idle;
    logic       cmd_valid;
    logic [5:0] cmd_index;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    logic [5:0] last_idx = '0;

    bit m_idle = 1'b1;
    bit m_app  = 1'b0;
    int m_polls = 0;

    sd_spi_card_model #(
        .INIT_POLLS(INIT_POLLS),
        .NCR_BYTES (NCR_BYTES),
        .OCR       (OCR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sd_cclk     (sd_cclk),
        .sd_cs       (sd_cs),
        .sd_mosi_cmd (sd_mosi_cmd),
        .sd_miso_data(sd_miso_data),
        .card_idle   (card_idle),
        .cmd_valid   (cmd_valid),
        .cmd_index   (cmd_index)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            valid_cnt++;
            last_idx = cmd_index;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] bits);
        logic [6:0]  c;
        logic [39:0] b;
        logic        fb;
        c = '0;
        b = bits;
        for (int i = 0; i < 40; i++) begin
            fb = c[6] ^ b[39];
            b  = b << 1;
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, crc7({2'b01, idx, arg}), 1'b1};
    endfunction

    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit crc_ok,
                             output logic [39:0] resp, output int nb);
        logic [7:0] r1;
        r1   = {7'b0, m_idle};
        nb   = 1;
        resp = '0;
        if (!crc_ok) begin
            resp = {r1 | 8'h08, 32'h0};
            return;
        end
        if (idx == 0) begin
            m_idle = 1'b1; m_polls = 0; resp = {8'h01, 32'h0};
        end else if (idx == 8) begin
            resp = {r1, 20'h0, arg[11:0]}; nb = 5;
        end else if (idx == 55) begin
            resp = {r1, 32'h0};
        end else if (idx == 41 && m_app) begin
            if (m_polls < INIT_POLLS) m_polls++;
            if (m_polls < INIT_POLLS) resp = {8'h01, 32'h0};
            else begin m_idle = 1'b0; resp = '0; end
        end else if (idx == 58) begin
            resp = {r1, OCR}; nb = 5;
        end else begin
            resp = {r1 | 8'h04, 32'h0};
        end
        m_app = (idx == 55);
    endtask

    task automatic send_bit(input logic b);
        sd_mosi_cmd = b;
        #(HALF); sd_cclk = 1'b1;
        #(HALF); sd_cclk = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic [7:0] t;
        t = tx;
        rx = '0;
        for (int i = 0; i < 8; i++) begin
            sd_mosi_cmd = t[7];
            t = t << 1;
            #(HALF); sd_cclk = 1'b1;
            rx = {rx[6:0], sd_miso_data};
            #(HALF); sd_cclk = 1'b0;
        end
    endtask

    task automatic abort_cs();
        #(HALF); sd_cs = 1'b1;
        #(HALF * 4);
        check("cs_high_miso", sd_miso_data, 1'b1);
        sd_cs = 1'b0;
        #(HALF * 2);
    endtask

    task automatic send_partial(input logic [47:0] frame, input int nb);
        logic [47:0] f;
        f = frame;
        for (int i = 0; i < nb; i++) begin
            send_bit(f[47]);
            f = f << 1;
        end
    endtask

    // mode 0: full transaction, 1: abort mid-command, 2: abort after first response byte
    task automatic run_cmd(input logic [47:0] frame, input int mode, output logic [39:0] got);
        logic [47:0] f;
        logic [39:0] ex;
        logic [7:0]  rx, acc;
        logic [5:0]  idx;
        int          nb, v0, nread;
        bit          crc_ok;
        got = '0;
        idx = frame[45:40];
        v0  = valid_cnt;
        if (mode == 1) begin
            send_partial(frame, $urandom_range(1, 47));
            abort_cs();
            check("abort_no_valid", valid_cnt - v0, 0);
            return;
        end
        f   = frame;
        acc = 8'hFF;
        for (int b = 0; b < 6; b++) begin
            xfer(f[47:40], rx);
            acc = acc & rx;
            f = f << 8;
        end
        check("cmd_phase_miso", acc, 8'hFF);
        check("cmd_valid_pulse", valid_cnt - v0, 1);
        check("cmd_index", last_idx, idx);
        crc_ok = (crc7(frame[47:8]) == frame[7:1]);
`ifndef SD_CARD_CRC_CHECK_EN
        crc_ok = 1'b1;
`endif
        model_cmd(idx, frame[39:8], crc_ok, ex, nb);
        for (int k = 0; k < NCR_BYTES; k++) begin
            xfer(8'hFF, rx);
            check("ncr_ones", rx, 8'hFF);
        end
        nread = (mode == 2) ? 1 : nb;
        for (int k = 0; k < nread; k++) begin
            xfer(8'hFF, rx);
            check("resp_byte", rx, ex[39:32]);
            got = {got[31:0], rx};
            ex  = ex << 8;
        end
        if (mode == 2) begin
            abort_cs();
        end else begin
            xfer(8'hFF, rx);
            check("post_resp_idle", rx, 8'hFF);
        end
        check("card_idle", card_idle, m_idle);
    endtask

    initial begin
        logic [39:0] got;
        logic [47:0] frame;
        logic [5:0]  idx;
        int          r, mode;

        repeat (4) @(negedge clk);
        check("rst_miso", sd_miso_data, 1'b1);
        check("rst_card_idle", card_idle, 1'b1);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_cmd_index", cmd_index, 6'd0);
        rst_n = 1'b1;
        sd_cs = 1'b0;
        #(HALF * 2);

        run_cmd(48'h400000000095, 0, got); check("cmd0_r1", got, 40'h01);
        run_cmd(48'h48000001AA87, 0, got); check("cmd8_r7", got, 40'h01000001AA);
        run_cmd(mk_frame(6'd55, 32'h0), 0, got); check("cmd55_a", got, 40'h01);
        run_cmd(mk_frame(6'd41, 32'h40000000), 0, got); check("acmd41_a", got, 40'h01);
        run_cmd(mk_frame(6'd55, 32'h0), 0, got); check("cmd55_b", got, 40'h01);
        run_cmd(mk_frame(6'd41, 32'h40000000), 0, got); check("acmd41_b", got, 40'h00);
        check("ready_idle", card_idle, 1'b0);
        run_cmd(mk_frame(6'd58, 32'h0), 0, got); check("cmd58_ocr", got, 40'h00C0FF8000);
        run_cmd(mk_frame(6'd17, 32'h1234), 0, got); check("cmd17_illegal", got, 40'h04);

        // Reset in the middle of a command frame.
        send_partial(mk_frame(6'd8, 32'h1AA), 20);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_miso", sd_miso_data, 1'b1);
        check("midrst_idle", card_idle, 1'b1);
        check("midrst_index", cmd_index, 6'd0);
        rst_n = 1'b1;
        m_idle = 1'b1; m_app = 1'b0; m_polls = 0;
        #(HALF * 2);
        run_cmd(mk_frame(6'd55, 32'h0), 0, got); check("postrst_cmd55", got, 40'h01);
        run_cmd(mk_frame(6'd41, 32'h0), 0, got); check("postrst_acmd41", got, 40'h01);

        run_cmd(48'h400000000095, 0, got); check("cmd0_again", got, 40'h01);
        run_cmd(mk_frame(6'd41, 32'h0), 0, got); check("cmd41_no_app", got, 40'h05);

        send_partial(48'h400000000095, 20);
        abort_cs();
        run_cmd(48'h400000000095, 0, got); check("cmd0_after_abort", got, 40'h01);

        run_cmd(48'h400000000097, 0, got); check("crc_bad_cmd0", got, CRC_EXP);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       idx = 6'd0;
                1, 2:    idx = 6'd55;
                3, 4:    idx = 6'd41;
                5:       idx = 6'd8;
                6:       idx = 6'd58;
                7:       idx = 6'd17;
                default: idx = 6'($urandom_range(0, 63));
            endcase
            frame = mk_frame(idx, $urandom());
            if ($urandom_range(0, 7) == 0) frame[7:1] = frame[7:1] ^ 7'($urandom_range(1, 127));
            mode = 0;
            if ($urandom_range(0, 9) == 0) mode = 1;
            else if ($urandom_range(0, 9) == 0) mode = 2;
            run_cmd(frame, mode, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sd_spi_card_model.md
SD_SPI_CARD_MODEL -- requirements
Module: sd_spi_card_model

Interface
REQ-001 Parameter INIT_POLLS, default 2: number of ACMD41 commands answered "idle" (R1=0x01) before the card reports ready.
REQ-002 Parameter NCR_BYTES, default 1: number of 0xFF bytes driven between the command end and the response.
REQ-003 Parameter OCR, default 32'hC0FF8000: OCR returned by CMD58.
REQ-004 clk  in  1  system clock; the single clock; all logic on posedge clk.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 sd_cclk  in  1  SPI clock from the host (mode 0); asynchronous to clk; clk SHALL be at least 8x sd_cclk.
REQ-007 sd_cs  in  1  chip select from the host, active-low, asynchronous.
REQ-008 sd_mosi_cmd  in  1  command bits from the host, MSB first.
REQ-009 sd_miso_data  out  1  response bits to the host, MSB first.
REQ-010 card_idle  out  1  R1 in_idle_state flag.
REQ-011 cmd_valid  out  1  one-clk pulse when a 48-bit command frame is accepted.
REQ-012 cmd_index  out  6  index of the last accepted command.

Function
REQ-013 sd_cclk, sd_cs and sd_mosi_cmd SHALL each pass through a 2-flop synchronizer; edges SHALL be detected from the synchronized sd_cclk.
REQ-014 On a detected sd_cclk rise with sd_cs low, the synchronized mosi bit SHALL shift into a 48-bit receive register.
REQ-015 On a detected sd_cclk fall with sd_cs low, sd_miso_data SHALL update to the next response bit; with no response pending it SHALL be 1.
REQ-016 FSM states: HUNT, RX_CMD, DECODE, NCR, TX_RESP.
REQ-017 HUNT: on a sampled 0 followed by a sampled 1 (start bit + transmission bit), go to RX_CMD; leading 1s are ignored.
REQ-018 RX_CMD: after 48 bits in total, go to DECODE; cmd_valid pulses and cmd_index loads bits [45:40] in the same cycle.
REQ-019 DECODE (1 clk): build the response shift register and its length, then go to NCR.
REQ-020 NCR: drive 1 for NCR_BYTES*8 sd_cclk falls, then go to TX_RESP.
REQ-021 TX_RESP: shift the response out MSB first, then go to HUNT with miso=1.
REQ-022 CMD0: R1 = 0x01; card_idle set; ACMD41 poll counter cleared; app_cmd flag cleared.
REQ-023 CMD8: R7, 40 bits = {R1, 20'h0, arg[11:8], arg[7:0]}, i.e. voltage and check pattern echoed.
REQ-024 CMD55: R1 = {7'b0, card_idle}; app_cmd flag set.
REQ-025 ACMD41 (CMD41 with app_cmd set): poll counter increments, saturating at INIT_POLLS. R1 = 0x01 while counter < INIT_POLLS after the increment; otherwise R1 = 0x00 and card_idle is cleared.
REQ-026 CMD58: 40 bits = {R1, OCR}.
REQ-027 Any other index, or CMD41 without app_cmd: R1 = 0x04 | card_idle.
REQ-028 app_cmd SHALL clear after any command other than CMD55.
REQ-029 R1 bit 7 SHALL always be 0.
REQ-030 If synchronized sd_cs rises in any state: go to HUNT, discard the partial frame and pending response, and drive miso=1. Flags (card_idle, app_cmd, poll counter) are retained.
REQ-031 Bits arriving during NCR/TX_RESP SHALL be ignored; there is no command pipelining.

Reset
REQ-032 With rst_n=0 at posedge clk: state=HUNT, sd_miso_data=1, card_idle=1, cmd_valid=0, cmd_index=0, app_cmd=0, poll counter=0, synchronizers=idle (cclk 0, cs 1, mosi 1).
REQ-033 A reset asserted mid-frame or mid-response SHALL abort immediately, with no partial output.

Configuration
REQ-034 With SD_CARD_CRC_CHECK_EN defined: CRC7 (poly x^7+x^3+1) SHALL be computed over bits [47:8] and compared with [7:1]. On mismatch, R1 = 0x08 | card_idle, and the command has no other effect (flags unchanged).
REQ-035 With SD_CARD_CRC_CHECK_EN undefined: CRC bits SHALL be ignored, and no CRC logic is instantiated.

Verification
REQ-036 Reset, then CMD0 (40 00 00 00 00 95) -> cmd_valid pulse, cmd_index=0, miso: 8 ones, then 0x01; card_idle=1.
REQ-037 CMD8 (48 00 00 01 AA 87) -> response 01 00 00 01 AA.
REQ-038 INIT_POLLS=2: CMD55+ACMD41 twice -> R1 sequence 01,01 then 01,00; card_idle=0 after the second ACMD41; next CMD58 -> 00 C0 FF 80 00.
REQ-039 CMD41 without CMD55 -> 0x05 while idle. CMD17 after init -> 0x04.
REQ-040 sd_cs raised after 20 command bits, lowered, then full CMD0 -> single response 0x01; no response for the aborted frame.
REQ-041 SD_CARD_CRC_CHECK_EN defined, CMD0 with CRC byte 0x97 -> 0x09, cmd_index=0. Same stimulus with the macro undefined -> 0x01.
